// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared FSM encoding and grant-width helper for the stream arbiter.
package axis_arb_pkg;

  localparam int unsigned ARB_STATE_W = 2;

  localparam logic [ARB_STATE_W-1:0] ARB_IDLE   = 2'd0;
  localparam logic [ARB_STATE_W-1:0] ARB_LOCKED = 2'd1;

  // Grant index width: max(1, clog2(n))
  function automatic int unsigned arb_grant_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational rotate-priority picker. Returns the first asserted
// request scanning ptr_i, ptr_i+1, ... with wrap from N-1 back to 0.
module arb_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_rot;
  logic [IDX_W:0] sum;

  assign req_dbl = {req_i, req_i};
  assign req_rot = req_dbl >> ptr_i;

  // Lowest set bit of the rotated vector, mapped back to an absolute index
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found_o && req_rot[j]) begin
        found_o = 1'b1;
        sum     = (IDX_W+1)'(ptr_i) + (IDX_W+1)'(j);
        if (sum >= (IDX_W+1)'(N)) begin
          sum = sum - (IDX_W+1)'(N);
        end
        idx_o = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin arbiter sharing one stream output among N_INPUTS
// requesters. Arbitration costs one IDLE cycle; once locked the granted lane is
// forwarded combinationally.
// Build option AXIS_ARB_PACKET_LOCK_EN: when defined the grant is held until a
// last-flagged handshake; when undefined every output handshake releases it.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N_INPUTS   = 4,
  parameter int unsigned GRANT_W    = arb_grant_w(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]            in_last,
  input  logic [N_INPUTS-1:0]            in_valid,
  output logic [N_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [GRANT_W-1:0]             grant_id,
  output logic                           grant_active
);

  logic [ARB_STATE_W-1:0] state_q, state_d;
  logic [GRANT_W-1:0]     grant_q, grant_d;
  logic [GRANT_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                   pick_found;
  logic [GRANT_W-1:0]     pick_idx;
  logic                   locked;
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   release_beat;

  arb_rr_pick #(
    .N     (N_INPUTS),
    .IDX_W (GRANT_W)
  ) u_pick (
    .req_i   (in_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign locked = (state_q == ARB_LOCKED);

  // Select the granted lane's valid/last/data
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        sel_valid = in_valid[i];
        sel_last  = in_last[i];
        sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output channel and per-lane ready, gated to zero outside LOCKED
  always_comb begin
    out_valid = locked & sel_valid;
    out_last  = locked & sel_last;
    out_data  = locked ? sel_data : '0;
    in_ready  = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      in_ready[i] = locked & (grant_q == GRANT_W'(i)) & out_ready;
    end
  end

  assign grant_id     = grant_q;
  assign grant_active = locked;

`ifdef AXIS_ARB_PACKET_LOCK_EN
  assign release_beat = out_valid & out_ready & out_last;
`else
  assign release_beat = out_valid & out_ready;
`endif

  // Next-state: arbitrate in IDLE, release on the closing handshake
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (release_beat) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_q == GRANT_W'(N_INPUTS - 1)) ? '0 : grant_q + GRANT_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, grant and rotation pointer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Round-robin arbiter sharing one AXI-Stream-style output channel between N_INPUTS requester streams.
- Typically placed in front of a skid_buffer, or of a downstream core's stream input, when several producers share one consumer.
- Grant is held for a whole packet, closed by a last-flagged beat, then rotates to the next requester.
- All ports follow AXI-Stream valid/ready rules, without TSTRB/TKEEP/TID/TDEST/TUSER.

Parameters:
- DATA_WIDTH, 8, beat data width in bits.
- N_INPUTS, 4, number of requester streams; legal range 2..16; need not be a power of two.
- GRANT_W, max(1, clog2(N_INPUTS)), width of the grant index; derived, do not override.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_data  input  N_INPUTS*DATA_WIDTH  flattened requester data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  input  N_INPUTS  per-requester end-of-packet flag.
- in_valid  input  N_INPUTS  per-requester valid.
- in_ready  output  N_INPUTS  per-requester ready; at most one bit high at any time.
- out_data  output  DATA_WIDTH  granted requester's data.
- out_last  output  1  granted requester's last flag.
- out_valid  output  1  output valid.
- out_ready  input  1  downstream ready.
- grant_id  output  GRANT_W  index of the current or most recent grant.
- grant_active  output  1  high while in the LOCKED state.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, grant_id = 0, rr_ptr = 0, grant_active = 0.
  - out_valid = 0, in_ready = all zero, out_data = 0, out_last = 0.
- States: IDLE, LOCKED (2-bit encoding, shared package).
- IDLE:
  - out_valid = 0, in_ready = 0.
  - If any in_valid is high, pick the first asserted index scanning rr_ptr, rr_ptr+1, ... with wrap from N_INPUTS-1 to 0.
  - Register it into grant_id and go to LOCKED next cycle.
  - If no in_valid is high, stay in IDLE; grant_id keeps its old value.
- LOCKED:
  - out_valid = in_valid[grant_id], out_data = data slice[grant_id], out_last = in_last[grant_id].
  - in_ready[grant_id] = out_ready; all other in_ready bits = 0.
  - These paths are combinational, so beat latency is zero once locked.
- Grant release: on a handshake (out_valid && out_ready) with out_last = 1, go to IDLE and set rr_ptr = grant_id+1, wrapping to 0 at N_INPUTS-1.
- Arbitration cost: one bubble cycle per packet; arbitration latency from first in_valid to out_valid is 1 cycle.
- Simultaneous release and new request: the release cycle does not re-arbitrate. The next grant is decided in the following IDLE cycle using the updated rr_ptr.
- A requester that drops in_valid mid-packet while granted violates protocol. The grant is still held; no recovery is required.
- Mid-packet stall (out_ready = 0): the arbiter holds state. Output data, last and valid stay stable, provided the granted input obeys stability rules.
- Reset mid-packet: the arbiter returns immediately to IDLE and clears rr_ptr. Partial packets are dropped and not recovered.
- Invariants:
  - out_valid implies grant_active.
  - popcount(in_ready) <= 1.
  - No input beat is accepted while in IDLE.
  - Every accepted input beat appears on the output in the same cycle.

Optional Feature:
- Macro: AXIS_ARB_PACKET_LOCK_EN.
- Defined: behaviour as above; the grant is held until a last-flagged handshake.
- Undefined: in_last is ignored for arbitration and every output handshake releases the grant, giving beat-level round robin with one bubble per beat. out_last still forwards in_last[grant_id] unchanged.

Decomposition:
- Package axis_arb_pkg:
  - state encoding constants ARB_IDLE, ARB_LOCKED.
  - clog2-based grant-width function.
- Natural sub-module: arb_rr_pick, a combinational rotate-priority picker.
  - Inputs: request vector, rr_ptr.
  - Outputs: found flag, index.
  - Instantiated once; unit-testable alone.
- Formal wrapper: reuses the existing axi_stream slave and master monitors on each input and on the output, with resetn tied to the DUT reset.

Test Plan:
- N_INPUTS=4; only input 2 valid with a 3-beat packet, out_ready=1 -> out_valid from cycle 1, grant_id=2, 3 beats out in order, then IDLE, rr_ptr=3.
- All 4 inputs continuously valid with 1-beat packets -> grant order 0,1,2,3,0, with one idle cycle between grants.
- Input 1 mid-packet with out_ready held low for 5 cycles, input 0 also valid -> out_data/out_last stable, grant stays 1, in_ready[0]=0 throughout.
- N_INPUTS=3, grant_id=2 releases with inputs 0 and 2 valid -> rr_ptr wraps to 0, next grant_id=0.
- resetn pulsed low during beat 2 of a 4-beat packet -> out_valid=0 and in_ready=0 in the same cycle; after release, arbitration restarts from index 0.
- Macro undefined, inputs 0 and 1 each with 2-beat packets -> output beats alternate 0,1,0,1.
